// File: rtl/spi_exchange_ctrl.sv
// Ping-pong send-buffer controller for the SPI slave PU: selects fill/drain buffers,
// swaps them between NITTA cycles outside SPI frames, and tracks word counts and errors.
module spi_exchange_ctrl #(
    parameter int unsigned BUF_SIZE  = 6,
    parameter int unsigned CNT_WIDTH = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 signal_cycle,
    input  logic                 signal_wr,
    input  logic                 cs_n,
    input  logic                 word_rd,
    input  logic                 err_clr,
    output logic                 buf_sel,
    output logic [1:0]           buf_clr,
    output logic [CNT_WIDTH-1:0] fill_cnt,
    output logic [CNT_WIDTH-1:0] drain_len,
    output logic [CNT_WIDTH-1:0] drain_cnt,
    output logic                 frame_active,
    output logic                 flag_stop,
    output logic                 overflow,
    output logic                 underrun
);

    localparam logic [CNT_WIDTH-1:0] BUF_MAX = CNT_WIDTH'(BUF_SIZE);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        SWAP   = 2'd2
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic                   pending_q;
    logic                   pending_d;
    logic                   prev_cs_n;
    logic                   fall;
    logic                   rise;
    logic                   swap_req;

    logic                   buf_sel_d;
    logic [1:0]             buf_clr_d;
    logic [CNT_WIDTH-1:0]   fill_cnt_d;
    logic [CNT_WIDTH-1:0]   drain_len_d;
    logic [CNT_WIDTH-1:0]   drain_cnt_d;
    logic                   frame_active_d;
    logic                   flag_stop_d;
    logic                   overflow_set;
    logic                   underrun_set;

    assign fall     = prev_cs_n & ~cs_n;
    assign rise     = ~prev_cs_n & cs_n;
    assign swap_req = pending_q | signal_cycle;

    // Next-state and next-output logic
    always_comb begin
        state_d        = state_q;
        pending_d      = pending_q | signal_cycle;
        buf_sel_d      = buf_sel;
        buf_clr_d      = 2'b00;
        fill_cnt_d     = fill_cnt;
        drain_len_d    = drain_len;
        drain_cnt_d    = drain_cnt;
        frame_active_d = frame_active;
        flag_stop_d    = 1'b0;
        overflow_set   = 1'b0;
        underrun_set   = 1'b0;

        // Saturating word accounting on both sides
        if (signal_wr) begin
            if (fill_cnt < BUF_MAX) begin
                fill_cnt_d = fill_cnt + CNT_ONE;
            end else begin
                overflow_set = 1'b1;
            end
        end
        if (word_rd) begin
            if (drain_cnt < drain_len) begin
                drain_cnt_d = drain_cnt + CNT_ONE;
            end else begin
                underrun_set = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (fall) begin
                    state_d        = ACTIVE;
                    frame_active_d = 1'b1;
                end else if (swap_req && cs_n) begin
                    state_d = SWAP;
                end
            end
            ACTIVE: begin
                if (rise) begin
                    flag_stop_d    = 1'b1;
                    frame_active_d = 1'b0;
                    state_d        = swap_req ? SWAP : IDLE;
                end
            end
            SWAP: begin
                // A write landing in this clk still targets the old fill buffer
                buf_sel_d   = ~buf_sel;
                drain_len_d = fill_cnt_d;
                fill_cnt_d  = '0;
                drain_cnt_d = '0;
                buf_clr_d   = buf_sel ? 2'b01 : 2'b10;
                if (fall) begin
                    state_d        = ACTIVE;
                    frame_active_d = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (state_d == SWAP) begin
            pending_d = 1'b0;
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            pending_q    <= 1'b0;
            prev_cs_n    <= 1'b1;
            buf_sel      <= 1'b0;
            buf_clr      <= 2'b11;
            fill_cnt     <= '0;
            drain_len    <= '0;
            drain_cnt    <= '0;
            frame_active <= 1'b0;
            flag_stop    <= 1'b0;
            overflow     <= 1'b0;
            underrun     <= 1'b0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            prev_cs_n    <= cs_n;
            buf_sel      <= buf_sel_d;
            buf_clr      <= buf_clr_d;
            fill_cnt     <= fill_cnt_d;
            drain_len    <= drain_len_d;
            drain_cnt    <= drain_cnt_d;
            frame_active <= frame_active_d;
            flag_stop    <= flag_stop_d;
            overflow     <= overflow_set | (overflow & ~err_clr);
            underrun     <= underrun_set | (underrun & ~err_clr);
        end
    end

endmodule

// File: tb/tb_spi_exchange_ctrl.sv
// Directed bench for spi_exchange_ctrl with hand-computed expectations.
module tb_spi_exchange_ctrl;

    logic       clk;
    logic       rst;
    logic       signal_cycle;
    logic       signal_wr;
    logic       cs_n;
    logic       word_rd;
    logic       err_clr;
    logic       buf_sel;
    logic [1:0] buf_clr;
    logic [2:0] fill_cnt;
    logic [2:0] drain_len;
    logic [2:0] drain_cnt;
    logic       frame_active;
    logic       flag_stop;
    logic       overflow;
    logic       underrun;

    int tests_run = 0;
    int tests_failed = 0;

    spi_exchange_ctrl #(.BUF_SIZE(6), .CNT_WIDTH(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .signal_cycle (signal_cycle),
        .signal_wr    (signal_wr),
        .cs_n         (cs_n),
        .word_rd      (word_rd),
        .err_clr      (err_clr),
        .buf_sel      (buf_sel),
        .buf_clr      (buf_clr),
        .fill_cnt     (fill_cnt),
        .drain_len    (drain_len),
        .drain_cnt    (drain_cnt),
        .frame_active (frame_active),
        .flag_stop    (flag_stop),
        .overflow     (overflow),
        .underrun     (underrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_buf_clr"}, 32'(buf_clr), 32'd3);
        check({tag, "_buf_sel"}, 32'(buf_sel), 32'd0);
        check({tag, "_fill"}, 32'(fill_cnt), 32'd0);
        check({tag, "_dlen"}, 32'(drain_len), 32'd0);
        check({tag, "_dcnt"}, 32'(drain_cnt), 32'd0);
        check({tag, "_frame"}, 32'(frame_active), 32'd0);
        check({tag, "_stop"}, 32'(flag_stop), 32'd0);
        check({tag, "_ovf"}, 32'(overflow), 32'd0);
        check({tag, "_unr"}, 32'(underrun), 32'd0);
    endtask

    initial begin
        rst = 1'b1; signal_cycle = 1'b0; signal_wr = 1'b0;
        cs_n = 1'b1; word_rd = 1'b0; err_clr = 1'b0;

        // Reset then idle
        tick();
        check_reset_values("rst");
        rst = 1'b0;
        tick();
        check("rst_clr_done", 32'(buf_clr), 32'd0);
        check("rst_idle_stop", 32'(flag_stop), 32'd0);

        // Basic swap: 4 writes then a cycle pulse in IDLE
        signal_wr = 1'b1;
        tick(4);
        signal_wr = 1'b0;
        check("basic_fill4", 32'(fill_cnt), 32'd4);
        signal_cycle = 1'b1;
        tick();
        signal_cycle = 1'b0;
        check("basic_sel_early", 32'(buf_sel), 32'd0);
        tick();
        check("basic_sel", 32'(buf_sel), 32'd1);
        check("basic_dlen", 32'(drain_len), 32'd4);
        check("basic_fill0", 32'(fill_cnt), 32'd0);
        check("basic_clr", 32'(buf_clr), 32'd2);
        tick();
        check("basic_clr_off", 32'(buf_clr), 32'd0);

        // Deferred swap: cycle pulse inside a frame
        cs_n = 1'b0;
        tick();
        check("def_frame", 32'(frame_active), 32'd1);
        signal_cycle = 1'b1;
        tick();
        signal_cycle = 1'b0;
        tick(18);
        check("def_sel_hold", 32'(buf_sel), 32'd1);
        cs_n = 1'b1;
        tick();
        check("def_stop", 32'(flag_stop), 32'd1);
        check("def_frame_end", 32'(frame_active), 32'd0);
        check("def_sel_still", 32'(buf_sel), 32'd1);
        tick();
        check("def_sel", 32'(buf_sel), 32'd0);
        check("def_stop_off", 32'(flag_stop), 32'd0);
        check("def_clr", 32'(buf_clr), 32'd1);
        check("def_dlen", 32'(drain_len), 32'd0);

        // Underrun: drain_len=2, three reads
        signal_wr = 1'b1;
        tick(2);
        signal_wr = 1'b0;
        signal_cycle = 1'b1;
        tick();
        signal_cycle = 1'b0;
        tick();
        check("unr_dlen", 32'(drain_len), 32'd2);
        check("unr_sel", 32'(buf_sel), 32'd1);
        cs_n = 1'b0;
        tick();
        word_rd = 1'b1;
        tick();
        check("unr_rd1", 32'(drain_cnt), 32'd1);
        tick();
        check("unr_rd2", 32'(drain_cnt), 32'd2);
        check("unr_flag_pre", 32'(underrun), 32'd0);
        tick();
        check("unr_rd3", 32'(drain_cnt), 32'd2);
        check("unr_flag", 32'(underrun), 32'd1);
        word_rd = 1'b0;
        cs_n = 1'b1;
        tick();
        check("unr_stop", 32'(flag_stop), 32'd1);
        tick();
        check("unr_no_swap", 32'(buf_sel), 32'd1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("unr_clr", 32'(underrun), 32'd0);

        // Overflow: 7 writes into a 6-word buffer
        signal_wr = 1'b1;
        tick(6);
        check("ovf_fill6", 32'(fill_cnt), 32'd6);
        check("ovf_pre", 32'(overflow), 32'd0);
        tick();
        signal_wr = 1'b0;
        check("ovf_fill_sat", 32'(fill_cnt), 32'd6);
        check("ovf_flag", 32'(overflow), 32'd1);
        err_clr = 1'b1;
        tick();
        check("ovf_clr", 32'(overflow), 32'd0);
        signal_wr = 1'b1;
        tick();
        check("ovf_set_wins", 32'(overflow), 32'd1);
        signal_wr = 1'b0;
        tick();
        err_clr = 1'b0;
        check("ovf_clr2", 32'(overflow), 32'd0);
        signal_cycle = 1'b1;
        tick();
        signal_cycle = 1'b0;
        tick();
        check("ovf_swap_dlen", 32'(drain_len), 32'd6);
        check("ovf_swap_sel", 32'(buf_sel), 32'd0);

        // Write in the SWAP clk lands in drain_len
        signal_wr = 1'b1;
        tick(3);
        signal_wr = 1'b0;
        signal_cycle = 1'b1;
        tick();
        signal_cycle = 1'b0;
        signal_wr = 1'b1;
        tick();
        signal_wr = 1'b0;
        check("swwr_dlen", 32'(drain_len), 32'd4);
        check("swwr_fill", 32'(fill_cnt), 32'd0);
        check("swwr_sel", 32'(buf_sel), 32'd1);

        // Fall coinciding with cycle pulse: frame first, swap after
        cs_n = 1'b0;
        signal_cycle = 1'b1;
        tick();
        signal_cycle = 1'b0;
        check("coin_frame", 32'(frame_active), 32'd1);
        tick(4);
        check("coin_sel_hold", 32'(buf_sel), 32'd1);
        cs_n = 1'b1;
        tick();
        check("coin_stop", 32'(flag_stop), 32'd1);
        tick();
        check("coin_sel", 32'(buf_sel), 32'd0);
        check("coin_dlen", 32'(drain_len), 32'd0);

        // Reset in the middle of a frame
        cs_n = 1'b0;
        tick();
        check("mid_frame", 32'(frame_active), 32'd1);
        signal_wr = 1'b1;
        tick(2);
        signal_wr = 1'b0;
        check("mid_fill", 32'(fill_cnt), 32'd2);
        rst = 1'b1;
        cs_n = 1'b1;
        tick();
        check_reset_values("mid_rst");
        rst = 1'b0;
        tick();
        check("mid_after_stop", 32'(flag_stop), 32'd0);
        check("mid_after_frame", 32'(frame_active), 32'd0);
        check("mid_after_clr", 32'(buf_clr), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/spi_exchange_ctrl.md
Name: spi_exchange_ctrl

Overview:
- Controller for the SPI slave processing unit's ping-pong send buffers.
- Decides which buffer NITTA fills and which one the SPI splitter drains.
- Swaps the buffers only at a safe point: a NITTA computational cycle has ended and no SPI frame is in progress.
- Counts words on both sides, generates the frame-end stop pulse, and flags overflow/underrun so the PU can report transfer errors.

Parameters:
- BUF_SIZE, 6, depth in words of each send buffer.
- CNT_WIDTH, 3, counter width; must satisfy 2^CNT_WIDTH > BUF_SIZE.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- signal_cycle  in  1  one-clk pulse: NITTA computational cycle boundary
- signal_wr  in  1  NITTA writes one word into the fill buffer this clk
- cs_n  in  1  bounce-filtered SPI chip select, active low
- word_rd  in  1  splitter pops one word from the drain buffer this clk
- err_clr  in  1  clears the sticky error flags
- buf_sel  out  1  0: buffer0 fills, buffer1 drains; 1: the opposite
- buf_clr  out  2  one-clk clear pulse per buffer, bit i = buffer i
- fill_cnt  out  CNT_WIDTH  words written into the current fill buffer
- drain_len  out  CNT_WIDTH  words available in the drain buffer, latched at swap
- drain_cnt  out  CNT_WIDTH  words popped from the drain buffer
- frame_active  out  1  SPI frame in progress
- flag_stop  out  1  one-clk pulse at frame end
- overflow  out  1  sticky: write attempted into a full fill buffer
- underrun  out  1  sticky: word_rd issued with drain_cnt == drain_len

Behaviour:
- Reset values, all registered outputs:
  - buf_sel=0, buf_clr=2'b11 (both buffers cleared in the reset cycle), then 0.
  - All counters = 0.
  - frame_active=0, flag_stop=0, overflow=0, underrun=0.
  - State IDLE, pending=0.
- cs_n is registered internally as prev_cs_n (reset value 1).
  - fall = prev_cs_n & !cs_n
  - rise = !prev_cs_n & cs_n
- pending latch:
  - Set by signal_cycle in any state.
  - Cleared only on entering SWAP.
- State machine, states IDLE, ACTIVE, SWAP:
  - IDLE, on fall: go to ACTIVE, frame_active<=1. fall has priority over pending; a swap is never performed while cs_n is low.
  - IDLE, no fall, pending (or signal_cycle this clk): go to SWAP.
  - ACTIVE, on rise: flag_stop<=1 for exactly one clk, frame_active<=0. Then go to SWAP if pending or signal_cycle, else IDLE.
  - ACTIVE, fall while already ACTIVE: impossible by edge definition; no action.
  - SWAP (one clk), in order:
    - buf_sel<=!buf_sel
    - drain_len<=fill_cnt + signal_wr, saturated at BUF_SIZE
    - fill_cnt<=0, drain_cnt<=0
    - buf_clr pulses for the buffer that was draining (it becomes the new fill buffer), so stale words are discarded
    - pending<=0
    - next state: IDLE; or ACTIVE if fall occurs in the SWAP clk.
- Swap latency:
  - signal_cycle in IDLE → buf_sel toggles 2 clks later (IDLE→SWAP, SWAP→toggle).
  - rise with pending → buf_sel toggles 2 clks after rise is seen.
- Write accounting:
  - signal_wr in the SWAP clk is steered by the old buf_sel, so it is counted into drain_len, not the new fill_cnt.
  - fill_cnt increments on signal_wr when fill_cnt < BUF_SIZE.
  - At BUF_SIZE it holds and sets overflow.
- Read accounting:
  - drain_cnt increments on word_rd when drain_cnt < drain_len.
  - Otherwise it holds and sets underrun.
  - word_rd outside ACTIVE is counted the same way; it is not an error by itself.
- Error flags:
  - err_clr clears both flags.
  - A set event in the same clk as err_clr wins (flag stays 1).
- rst mid-frame or mid-SWAP:
  - Immediate return to reset values; no flag_stop is emitted.
  - The next frame start is detected only after cs_n has been seen high (prev_cs_n=1).
- Counter arithmetic is unsigned CNT_WIDTH with saturation; no wrap-around is permitted.

Test Plan:
- Reset then idle: rst 1 clk, cs_n=1 → buf_clr=2'b11 in the reset clk; buf_sel=0; all counters 0; no flag_stop.
- Basic swap: 4 signal_wr, then signal_cycle in IDLE → buf_sel=1 two clks after the pulse; drain_len=4; fill_cnt=0; buf_clr=2'b10 for one clk.
- Deferred swap:
  - Stimulus: cs_n low; signal_cycle during the frame; cs_n high after 20 clks.
  - Response: buf_sel unchanged while cs_n=0; flag_stop one clk after rise is seen; buf_sel toggles the following clk.
- Overflow: 7 signal_wr with BUF_SIZE=6 → fill_cnt=6, overflow=1; err_clr → overflow=0.
- Underrun: drain_len=2; 3 word_rd pulses in a frame → drain_cnt=2, underrun=1 after the third pulse.
- Simultaneous events:
  - signal_wr in the SWAP clk → counted in drain_len (3 earlier writes give drain_len=4).
  - fall coinciding with signal_cycle in IDLE → ACTIVE first; swap occurs after the frame end.
  - rst at frame midpoint → no flag_stop; all outputs at reset values.
